serial_substractor: RTL

- Bit-serial N-bit subtractor computing diff = a - b - b_in.
- Drives the existing combinational full_substractor cell one bit per clock, LSB first, and captures its diff/borrow outputs into a result shift register and a borrow flip-flop.
- Sits directly around the 1-bit cell: sequences operands into it and collects what it produces.
- Handshake is start/busy/done, so a controller can request a multi-bit subtraction using one 1-bit cell.

---
 rtl/serial_substractor_pkg.sv | 8 +
 rtl/full_substractor.sv | 11 +
 rtl/serial_substractor.sv | 77 +++++++
 3 files changed

// File: rtl/serial_substractor_pkg.sv
// serial_substractor_pkg: state encoding shared by the bit-serial subtractor.
package serial_substractor_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/full_substractor.sv
// full_substractor: combinational 1-bit subtractor cell, diff = a - b - b_in.
module full_substractor (
    input  logic a,
    input  logic b,
    input  logic b_in,
    output logic diff,
    output logic borrow
);
    assign diff   = a ^ b ^ b_in;
    assign borrow = (~a & (b | b_in)) | (b & b_in);
endmodule

// File: rtl/serial_substractor.sv
// serial_substractor: N-bit a - b - b_in computed LSB first through one full_substractor cell.
module serial_substractor
    import serial_substractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    localparam int CW = $clog2(WIDTH);
    state_t           state;
    logic [WIDTH-1:0] a_sr, b_sr, diff_sr;
    logic             bor, cell_d, cell_b;
    logic [CW-1:0]    cnt;
    full_substractor u_cell (
        .a      (a_sr[0]),
        .b      (b_sr[0]),
        .b_in   (bor),
        .diff   (cell_d),
        .borrow (cell_b)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            a_sr       <= '0;
            b_sr       <= '0;
            diff_sr    <= '0;
            bor        <= 1'b0;
            cnt        <= '0;
        end else begin
            case (state)
                ST_SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= {cell_d, diff_sr[WIDTH-1:1]};
                    bor     <= cell_b;
                    cnt     <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= {cell_d, diff_sr[WIDTH-1:1]};
                        borrow_out <= cell_b;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= start;
                    state <= start ? ST_SHIFT : ST_IDLE;
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        bor  <= b_in;
                        cnt  <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
